// File: rtl/ascon_mask_prng_if.sv
// Bundle of control, static-mask and fresh-randomness signals between the mask PRNG
// and its user (the launcher/testbench side is master, the PRNG is slave).
interface ascon_mask_prng_if #(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 40
);
    logic           seed_valid;
    logic [63:0]    seed;
    logic           start_req;
    logic           encryption_ready;
    logic           encryption_start;
    logic           masks_valid;
    logic           busy;
    logic [K-1:0]   random_key_1;
    logic [K-1:0]   random_key_2;
    logic [127:0]   random_nonce_1;
    logic [127:0]   random_nonce_2;
    logic [L-1:0]   random_ad_1;
    logic [L-1:0]   random_ad_2;
    logic [Y-1:0]   random_pt_1;
    logic [Y-1:0]   random_pt_2;
    logic [63:0]    r0, r1, r2, r3, r4, r5, r6;

    modport master (
        output seed_valid, seed, start_req, encryption_ready,
        input  encryption_start, masks_valid, busy,
        input  random_key_1, random_key_2, random_nonce_1, random_nonce_2,
        input  random_ad_1, random_ad_2, random_pt_1, random_pt_2,
        input  r0, r1, r2, r3, r4, r5, r6
    );

    modport slave (
        input  seed_valid, seed, start_req, encryption_ready,
        output encryption_start, masks_valid, busy,
        output random_key_1, random_key_2, random_nonce_1, random_nonce_2,
        output random_ad_1, random_ad_2, random_pt_1, random_pt_2,
        output r0, r1, r2, r3, r4, r5, r6
    );
endinterface

// File: rtl/ascon_mask_prng.sv
// xorshift64 mask source and launcher for the 3-share threshold Ascon core:
// fills static mask shares, streams seven fresh-randomness lanes, and pulses encryption_start.
module ascon_mask_prng #(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ascon_mask_prng_if.slave     bus
);

    localparam int M     = 2*K + 256 + 2*L + 2*Y;
    localparam int W     = (M + 63) / 64;
    localparam int BUF_W = W * 64;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

    typedef enum logic [2:0] {IDLE, FILL, START, GAP, RUN} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [63:0]            prng;
    logic [BUF_W-1:0]       mask_buf;
    logic [6:0][63:0]       lanes;
    logic [6:0][63:0]       r;
    logic                   target_done;
    logic [CNT_W-1:0]       fill_cnt;
    logic [63:0]            fill_word;
    logic [63:0]            lane_base;
    logic                   fill_last;

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    // Each lane gets a distinct byte-replicated tag so no two lanes start equal.
    function automatic logic [63:0] lane_seed(input logic [63:0] base, input int idx);
        logic [7:0]  tag;
        logic [63:0] v;
        tag = 8'(idx + 1);
        v   = base ^ {8{tag}};
        return (v == 64'd0) ? GOLDEN : v;
    endfunction

    assign fill_word = xs64(prng);
    assign lane_base = xs64(fill_word);
    assign fill_last = (fill_cnt == CNT_W'(W - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_req) state_next = FILL;
            FILL:    if (fill_last) state_next = START;
            START:   state_next = target_done ? GAP : RUN;
            GAP:     state_next = START;
            RUN:     if (bus.encryption_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A seed accepted together with start_req is in prng before the first FILL cycle uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prng        <= GOLDEN;
            mask_buf    <= '0;
            lanes       <= '0;
            r           <= '0;
            target_done <= 1'b0;
            fill_cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    fill_cnt <= '0;
                    if (bus.seed_valid)
                        prng <= (bus.seed == 64'd0) ? GOLDEN : bus.seed;
                end
                FILL: begin
                    mask_buf <= {mask_buf[BUF_W-65:0], fill_word};
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_last) begin
                        prng <= lane_base;
                        for (int i = 0; i < 7; i++)
                            lanes[i] <= lane_seed(lane_base, i);
                    end else begin
                        prng <= fill_word;
                    end
                end
                START: begin
                    if (target_done)
                        target_done <= 1'b0;
                end
                RUN: begin
                    for (int i = 0; i < 7; i++) begin
                        lanes[i] <= xs64(lanes[i]);
                        r[i]     <= xs64(lanes[i]);
                    end
                    if (bus.encryption_ready)
                        target_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.encryption_start = (state == START);
    assign bus.masks_valid      = (state == START) || (state == GAP) || (state == RUN);
    assign bus.busy             = (state != IDLE);

    assign {bus.random_key_1,   bus.random_key_2,
            bus.random_nonce_1, bus.random_nonce_2,
            bus.random_ad_1,    bus.random_ad_2,
            bus.random_pt_1,    bus.random_pt_2} = mask_buf[BUF_W-1 -: M];

    assign bus.r0 = r[0];
    assign bus.r1 = r[1];
    assign bus.r2 = r[2];
    assign bus.r3 = r[3];
    assign bus.r4 = r[4];
    assign bus.r5 = r[5];
    assign bus.r6 = r[6];

endmodule

// File: tb/tb_ascon_mask_prng.sv
// Randomized scoreboard bench for ascon_mask_prng against a word-level xorshift64 reference.
module tb_ascon_mask_prng;

    localparam int K = 128;
    localparam int L = 40;
    localparam int Y = 40;
    localparam int M = 2*K + 256 + 2*L + 2*Y;
    localparam int W = (M + 63) / 64;
    localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

    typedef struct {
        logic [M-1:0]     masks;
        logic [6:0][63:0] lanes;
        bit               dbl;
    } run_rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ascon_mask_prng_if #(.K(K), .L(L), .Y(Y)) bus();

    ascon_mask_prng #(.K(K), .L(L), .Y(Y)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [M-1:0]     dut_masks;
    logic [6:0][63:0] dut_r;
    assign dut_masks = {bus.random_key_1, bus.random_key_2, bus.random_nonce_1, bus.random_nonce_2,
                        bus.random_ad_1, bus.random_ad_2, bus.random_pt_1, bus.random_pt_2};
    assign dut_r = {bus.r6, bus.r5, bus.r4, bus.r3, bus.r2, bus.r1, bus.r0};

    int checks = 0;
    int passes = 0;
    run_rec_t sb[$];
    logic [63:0] model_prng = GOLDEN;
    bit model_td = 1'b0;

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [M-1:0] actual, input logic [M-1:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Reference: W successive xorshift words laid out MSB-first, one more step seeds the lanes.
    task automatic modelRun();
        logic [W*64-1:0]  words;
        logic [63:0]      lane_src;
        logic [63:0]      v;
        logic [7:0]       tag;
        run_rec_t         rec;
        words = '0;
        for (int j = 0; j < W; j++) begin
            model_prng = xs(model_prng);
            words[(W-1-j)*64 +: 64] = model_prng;
        end
        rec.masks = words[W*64-1 -: M];
        lane_src = xs(model_prng);
        model_prng = lane_src;
        for (int i = 0; i < 7; i++) begin
            tag = 8'(i + 1);
            v = lane_src ^ {8{tag}};
            rec.lanes[i] = (v == 64'd0) ? GOLDEN : v;
        end
        rec.dbl = model_td;
        model_td = 1'b0;
        sb.push_back(rec);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_masks"}, dut_masks, '0);
        checkOutput({tag, "_r"}, M'(dut_r), '0);
        checkOutput({tag, "_flags"}, M'({bus.encryption_start, bus.masks_valid, bus.busy}), '0);
    endtask

    // One encryption: request, let the core model finish (or reset mid-RUN), junk inputs while busy.
    task automatic applyStimulus(input bit do_seed, input logic [63:0] s, input bit abort_run);
        int  n_ready;
        int  mv_cnt;
        bit  finished;
        n_ready  = $urandom_range(4, 15);
        mv_cnt   = 0;
        finished = 1'b0;
        @(negedge clk);
        bus.seed_valid = do_seed;
        bus.seed       = s;
        bus.start_req  = 1'b1;
        if (do_seed) model_prng = (s == 64'd0) ? GOLDEN : s;
        modelRun();
        @(negedge clk);
        bus.seed_valid = 1'b0;
        bus.start_req  = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (bus.masks_valid) mv_cnt++;
            if (abort_run && mv_cnt == n_ready) begin
                #2 rst_n = 1'b0;
                #1 checkResetState("abort");
                model_prng = GOLDEN;
                model_td   = 1'b0;
                bus.encryption_ready = 1'b0;
                bus.start_req  = 1'b0;
                bus.seed_valid = 1'b0;
                @(negedge clk);
                #3 rst_n = 1'b1;
                return;
            end
            bus.encryption_ready = (mv_cnt == n_ready);
            bus.start_req  = (mv_cnt >= 1 && mv_cnt < n_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.seed_valid = (mv_cnt >= 1 && mv_cnt < n_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.seed       = {$urandom, $urandom};
            if (mv_cnt == n_ready) begin
                model_td = 1'b1;
                finished = 1'b1;
            end
            @(negedge clk);
        end
        bus.encryption_ready = 1'b0;
        bus.start_req  = 1'b0;
        bus.seed_valid = 1'b0;
        if (finished) checkOutput("return_idle", M'(bus.busy), '0);
        else          checkOutput("run_timeout", M'(mv_cnt), M'(n_ready));
    endtask

    // Monitor: pops a run record on each first start pulse and follows it through GAP/RUN.
    int       phase = 0;
    int       busy_cnt = 0;
    bit       prev_run = 1'b0;
    bit       distinct;
    run_rec_t cur;
    logic [6:0][63:0] exp_lane;

    always @(negedge clk) begin
        if (!rst_n) begin
            phase    = 0;
            busy_cnt = 0;
            prev_run = 1'b0;
        end else begin
            if (prev_run) begin
                for (int i = 0; i < 7; i++) exp_lane[i] = xs(exp_lane[i]);
                checkOutput("r_step", M'(dut_r), M'(exp_lane));
                checkOutput("mask_hold", dut_masks, cur.masks);
                distinct = 1'b1;
                for (int i = 0; i < 7; i++)
                    for (int j = i + 1; j < 7; j++)
                        if (dut_r[i] == dut_r[j]) distinct = 1'b0;
                checkOutput("lanes_distinct", M'(distinct), M'(1));
            end
            prev_run = 1'b0;
            busy_cnt = bus.busy ? busy_cnt + 1 : 0;
            case (phase)
                0: if (bus.encryption_start) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_start", M'(1), M'(0));
                    end else begin
                        cur = sb.pop_front();
                        checkOutput("start_latency", M'(busy_cnt), M'(W + 1));
                        checkOutput("masks", dut_masks, cur.masks);
                        checkOutput("masks_valid_at_start", M'(bus.masks_valid), M'(1));
                        exp_lane = cur.lanes;
                        phase = cur.dbl ? 1 : 3;
                    end
                end
                1: begin
                    checkOutput("gap_pulse_low", M'({bus.encryption_start, bus.masks_valid}), M'(2'b01));
                    phase = 2;
                end
                2: begin
                    checkOutput("second_pulse", M'({bus.encryption_start, bus.masks_valid}), M'(2'b11));
                    phase = 3;
                end
                default: begin
                    if (bus.busy) begin
                        checkOutput("run_no_pulse", M'({bus.encryption_start, bus.masks_valid}), M'(2'b01));
                        prev_run = 1'b1;
                    end else begin
                        phase = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        bus.seed_valid       = 1'b0;
        bus.seed             = '0;
        bus.start_req        = 1'b0;
        bus.encryption_ready = 1'b0;
        #3 checkResetState("reset");
        @(negedge clk);
        #3 rst_n = 1'b1;

        applyStimulus(1'b1, 64'h1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, 64'h0, 1'b0);
        applyStimulus(1'b1, GOLDEN, 1'b0);

        // Seed loaded on its own in IDLE, consumed by a later request.
        @(negedge clk);
        bus.seed_valid = 1'b1;
        bus.seed       = {$urandom, $urandom};
        model_prng     = (bus.seed == 64'd0) ? GOLDEN : bus.seed;
        @(negedge clk);
        bus.seed_valid = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0);

        for (int n = 0; n < 4; n++)
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0);

        applyStimulus(1'b1, {$urandom, $urandom}, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", M'(sb.size()), '0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
